key_sweep_ctrl: RTL and testbench

//  Oracle-guided key-sweep controller for the XOR-locked adder datapath.

---
 rtl/key_sweep_ctrl_if.sv | 33 +++
 rtl/key_sweep_ctrl.sv | 159 +++++++++++++++
 tb/tb_key_sweep_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_sweep_ctrl_if.sv
// key_sweep_ctrl_if
//   Stimulus/response bus between the key-sweep controller and the
//   locked-adder / oracle-adder pair.
//   Ports (signals):
//     vec_a, vec_b  [W-1:0]  operands driven by the controller
//     vec_c                  carry-in driven by the controller
//     key_try       [W-1:0]  candidate key for the locked adder
//     dut_s         [W:0]    locked-adder sum (combinational from vec_*/key_try)
//     orc_s         [W:0]    oracle sum (combinational from vec_*)
//   Handshake: none. The controller holds vec_*/key_try steady for the whole
//   vector slot. Both sums must be valid by the edge that ends the slot,
//   which is the edge where they are compared.
//   Modports: master = controller side, slave = adder-pair side.
interface key_sweep_ctrl_if #(
  parameter int W = 2
);
  logic [W-1:0] vec_a;
  logic [W-1:0] vec_b;
  logic         vec_c;
  logic [W-1:0] key_try;
  logic [W:0]   dut_s;
  logic [W:0]   orc_s;

  modport master (
    output vec_a, vec_b, vec_c, key_try,
    input  dut_s, orc_s
  );

  modport slave (
    input  vec_a, vec_b, vec_c, key_try,
    output dut_s, orc_s
  );
endinterface

// File: rtl/key_sweep_ctrl.sv
// key_sweep_ctrl
//   Oracle-guided key sweep for an XOR-locked adder. For each candidate key
//   it walks every (a,b,c) vector. On the first sum mismatch the key is
//   rejected. The first key whose vectors all match is reported.
//   Ports:
//     clk, rst         clock, asynchronous active-high reset
//     start, abort     begin sweep (IDLE only) / cancel sweep (busy states)
//     bus (master)     vec_a/vec_b/vec_c/key_try out, dut_s/orc_s in
//     busy             high in APPLY/WAIT/CMP
//     done             one-cycle pulse when a sweep ends (not on abort)
//     found, key_out   a key passed / which one (0 when none)
//     rej_cnt          keys rejected in the current/last sweep
//     state_dbg        current FSM state encoding
module key_sweep_ctrl #(
  parameter int W      = 2,
  parameter int SETTLE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  key_sweep_ctrl_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [W-1:0]      key_out,
  output logic [W:0]        rej_cnt,
  output logic [2:0]        state_dbg
);

  localparam int VW = 2 * W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CMP   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [VW-1:0] V_LAST = '1;
  localparam logic [W-1:0]  K_LAST = '1;
  // A slot is APPLY + (SETTLE-1) WAIT cycles + CMP = SETTLE+1 cycles.
  // WAIT is only entered when SETTLE >= 2.
  localparam logic [3:0] WAIT_LAST = (SETTLE >= 2) ? 4'(SETTLE - 2) : 4'd0;

  state_t        state;
  logic [VW-1:0] v;
  logic [W-1:0]  key;
  logic [3:0]    settle_cnt;
  logic          match;
  logic          do_cmp;
  logic          in_busy;

  assign bus.vec_a   = v[W-1:0];
  assign bus.vec_b   = v[2*W-1:W];
  assign bus.vec_c   = v[2*W];
  assign bus.key_try = key;
  assign state_dbg   = state;

  assign match   = (bus.dut_s == bus.orc_s);
  // With no settle time the APPLY cycle doubles as the compare cycle.
  assign do_cmp  = (state == S_CMP) || ((state == S_APPLY) && (SETTLE == 0));
  assign in_busy = (state == S_APPLY) || (state == S_WAIT) || (state == S_CMP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      v          <= '0;
      key        <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      key_out    <= '0;
      rej_cnt    <= '0;
    end else if (abort && in_busy) begin
      // Cancel: keep the partial rejection count, no done pulse.
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      found <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            state      <= S_APPLY;
            busy       <= 1'b1;
            key        <= '0;
            v          <= '0;
            settle_cnt <= '0;
            rej_cnt    <= '0;
            found      <= 1'b0;
            key_out    <= '0;
          end
        end
        S_APPLY: begin
          if (SETTLE == 1) begin
            state <= S_CMP;
          end else if (SETTLE > 1) begin
            state      <= S_WAIT;
            settle_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (settle_cnt == WAIT_LAST) begin
            state <= S_CMP;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_CMP: begin
          // Outcome handled by the compare block below.
        end
        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase

      // Compare outcome overrides the state update above.
      if (do_cmp) begin
        if (match) begin
          if (v == V_LAST) begin
            found   <= 1'b1;
            key_out <= key;
            state   <= S_FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            v     <= v + 1'b1;
            state <= S_APPLY;
          end
        end else begin
          // Early reject: the remaining vectors for this key are skipped.
          rej_cnt <= rej_cnt + 1'b1;
          v       <= '0;
          if (key == K_LAST) begin
            found   <= 1'b0;
            key_out <= '0;
            state   <= S_FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            key   <= key + 1'b1;
            state <= S_APPLY;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_key_sweep_ctrl.sv
// tb_key_sweep_ctrl
//   Bench for key_sweep_ctrl with two instances: SETTLE=0 (inst0) and
//   SETTLE=3 (inst3). A behavioural locked-adder model selected by mode0/mode3
//   drives dut_s, and a plain adder drives orc_s. Sweep results are pushed to
//   per-instance expected queues and popped by monitors on done.
//   The expected word is {latency[15:0], found, key_out[1:0], rej_cnt[2:0]}.
module tb_key_sweep_ctrl;
  localparam int W  = 2;
  localparam int RW = 22;
  localparam logic [W-1:0] LOCK_KEY = 2'b10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT wiring ----------------
  logic start0, abort0, busy0, done0, found0;
  logic [W-1:0] key_out0;
  logic [W:0]   rej_cnt0;
  logic [2:0]   state0;
  logic start3, abort3, busy3, done3, found3;
  logic [W-1:0] key_out3;
  logic [W:0]   rej_cnt3;
  logic [2:0]   state3;
  int mode0, mode3;

  key_sweep_ctrl_if #(.W(W)) bus0 ();
  key_sweep_ctrl_if #(.W(W)) bus3 ();

  function automatic logic [W:0] orc_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  // mode 0: key 2 unlocks; mode 1: always off by one; mode 2: key 3 unlocks,
  // other keys fail only at the all-ones vector.
  function automatic logic [W:0] dut_f(input int mode, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic c,
                                       input logic [W-1:0] k);
    logic [W:0] s;
    s = orc_f(a, b, c);
    if (mode == 0) begin
      s = {1'b0, a ^ k ^ LOCK_KEY} + {1'b0, b} + (W+1)'(c);
    end else if (mode == 1) begin
      s = s + 1'b1;
    end else begin
      if (k != 2'd3 && a == 2'd3 && b == 2'd3 && c == 1'b1) s = s ^ 3'b001;
    end
    return s;
  endfunction

  assign bus0.orc_s = orc_f(bus0.vec_a, bus0.vec_b, bus0.vec_c);
  assign bus0.dut_s = dut_f(mode0, bus0.vec_a, bus0.vec_b, bus0.vec_c, bus0.key_try);
  assign bus3.orc_s = orc_f(bus3.vec_a, bus3.vec_b, bus3.vec_c);
  assign bus3.dut_s = dut_f(mode3, bus3.vec_a, bus3.vec_b, bus3.vec_c, bus3.key_try);

  key_sweep_ctrl #(.W(W), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .bus(bus0),
    .busy(busy0), .done(done0), .found(found0), .key_out(key_out0),
    .rej_cnt(rej_cnt0), .state_dbg(state0)
  );

  key_sweep_ctrl #(.W(W), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .bus(bus3),
    .busy(busy3), .done(done3), .found(found3), .key_out(key_out3),
    .rej_cnt(rej_cnt3), .state_dbg(state3)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [RW-1:0] exp_q0[$];
  logic [RW-1:0] exp_q3[$];
  logic [RW-1:0] e0, e3;
  int t0 = 0;
  int t3 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done0) begin
      if (exp_q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done0_unexpected: got done=1 expected no done");
      end else begin
        e0 = exp_q0.pop_front();
        check("sweep0", {16'(cyc - t0), found0, key_out0, rej_cnt0}, 32'(e0));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done3) begin
      if (exp_q3.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done3_unexpected: got done=1 expected no done");
      end else begin
        e3 = exp_q3.pop_front();
        check("sweep3", {16'(cyc - t3), found3, key_out3, rej_cnt3}, 32'(e3));
      end
    end
  end

  // Each (key, vector) pair must stay on the bus for SETTLE+1 = 4 cycles.
  logic [2*W+W:0] prev_vk, cur_vk;
  int  run3  = 0;
  bit  have3 = 1'b0;
  always @(negedge clk) begin
    if (busy3) begin
      cur_vk = {bus3.key_try, bus3.vec_c, bus3.vec_b, bus3.vec_a};
      if (have3 && cur_vk != prev_vk) begin
        check("vec_hold3", 32'(run3), 32'd4);
        run3 = 1;
      end else if (have3) begin
        run3++;
      end else begin
        have3 = 1'b1;
        run3  = 1;
      end
      prev_vk = cur_vk;
    end else begin
      have3 = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic go0(input int hold);
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    repeat (hold - 1) @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic go3(input int hold);
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1 t3 = cyc;
    repeat (hold - 1) @(posedge clk);
    @(negedge clk);
    start3 = 1'b0;
  endtask

  task automatic wait_done0(input int budget);
    int n = 0;
    while (!done0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done0) begin
      total++;
      bad++;
      $display("FAIL timeout0: got no done in %0d cycles expected done", budget);
    end
  endtask

  task automatic wait_done3(input int budget);
    int n = 0;
    while (!done3 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done3) begin
      total++;
      bad++;
      $display("FAIL timeout3: got no done in %0d cycles expected done", budget);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    start0 = 1'b0; abort0 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    mode0 = 0; mode3 = 0;
    repeat (3) @(negedge clk);
    check("rst_out0", {busy0, done0, found0, key_out0, rej_cnt0, bus0.vec_a, bus0.vec_b,
                       bus0.vec_c, bus0.key_try, state0}, 32'd0);
    check("rst_out3", {busy3, done3, found3, key_out3, rej_cnt3, bus3.vec_a, bus3.vec_b,
                       bus3.vec_c, bus3.key_try, state3}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Key 2 unlocks; start held for 20 cycles must not disturb the sweep.
    mode0 = 0;
    exp_q0.push_back({16'd34, 1'b1, 2'd2, 3'd2});
    go0(20);
    wait_done0(200);
    @(negedge clk);
    check("idle_hold0", {done0, busy0, found0, key_out0, rej_cnt0, state0},
          {1'b0, 1'b0, 1'b1, 2'd2, 3'd2, 3'd0});

    // No key unlocks.
    mode0 = 1;
    exp_q0.push_back({16'd4, 1'b0, 2'd0, 3'd4});
    go0(1);
    wait_done0(50);
    @(negedge clk);
    check("none_found0", {found0, key_out0, rej_cnt0}, {1'b0, 2'd0, 3'd4});

    // Abort 10 cycles into a sweep.
    mode0 = 0;
    go0(1);
    repeat (10) @(negedge clk);
    check("pre_abort0", {busy0, rej_cnt0}, {1'b1, 3'd2});
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    check("post_abort0", {busy0, done0, found0, state0, rej_cnt0},
          {1'b0, 1'b0, 1'b0, 3'd0, 3'd2});
    repeat (40) @(negedge clk);
    check("abort_idle0", {busy0, state0}, 4'd0);
    exp_q0.push_back({16'd34, 1'b1, 2'd2, 3'd2});
    go0(1);
    wait_done0(200);
    @(negedge clk);

    // Wrong keys fail only at the last vector.
    mode0 = 2;
    exp_q0.push_back({16'd128, 1'b1, 2'd3, 3'd3});
    go0(1);
    wait_done0(400);
    @(negedge clk);

    // SETTLE=3: four cycles per vector.
    mode3 = 0;
    exp_q3.push_back({16'd136, 1'b1, 2'd2, 3'd2});
    go3(1);
    wait_done3(600);
    @(negedge clk);

    // Asynchronous reset while in WAIT.
    go3(1);
    repeat (5) @(negedge clk);
    check("mid_wait3", {state3, rej_cnt3}, {3'd2, 3'd1});
    #2 rst = 1'b1;
    #1;
    check("async_rst3", {busy3, done3, found3, key_out3, rej_cnt3, bus3.vec_a, bus3.vec_b,
                         bus3.vec_c, bus3.key_try, state3}, 32'd0);
    check("async_rst0", {found0, key_out0, rej_cnt0, state0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("no_resume3", {busy3, state3}, 4'd0);

    // start and abort together in IDLE: stays idle.
    start0 = 1'b1; abort0 = 1'b1; start3 = 1'b1; abort3 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; abort0 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    check("start_abort0", {busy0, state0}, 4'd0);
    check("start_abort3", {busy3, state3}, 4'd0);
    repeat (3) @(negedge clk);

    check("q0_drained", 32'(exp_q0.size()), 32'd0);
    check("q3_drained", 32'(exp_q3.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish by 1ms");
    $fatal(1, "watchdog");
  end

endmodule
